// File: rtl/mem_lsu_if.sv
// Data-memory request/response channel between the load/store unit (master)
// and the data memory (slave).
`ifndef MEMOP_LEN
`define MEMOP_LEN 4
`endif
`ifndef TRAP_LEN
`define TRAP_LEN 70
`endif

interface mem_lsu_if #(
    parameter int XLEN   = 64,
    parameter int STRB_W = XLEN / 8
);
    logic              req_valid;
    logic              req_ready;
    logic [XLEN-1:0]   req_addr;
    logic              req_wen;
    logic [XLEN-1:0]   req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: issues one data-memory access per EX/MEM entry
// and formats the registered result for MEM/WB. Option: MEM_MISALIGN_TRAP_EN.
`ifndef MEMOP_LEN
`define MEMOP_LEN 4
`endif
`ifndef TRAP_LEN
`define TRAP_LEN 70
`endif

module mem_lsu #(
    parameter int XLEN   = 64,
    parameter int STRB_W = XLEN / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [XLEN-1:0]       pc_i,
    input  logic [4:0]            rd_idx_i,
    input  logic [XLEN-1:0]       alu_data_i,
    input  logic [XLEN-1:0]       rs2_data_i,
    input  logic [`MEMOP_LEN-1:0] mem_op_i,
    input  logic [`TRAP_LEN-1:0]  trap_bus_i,
    mem_lsu_if.master             mem,
    output logic                  out_valid_o,
    output logic [XLEN-1:0]       out_pc_o,
    output logic [4:0]            out_rd_idx_o,
    output logic [XLEN-1:0]       out_rd_data_o,
    output logic [`TRAP_LEN-1:0]  out_trap_bus_o
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_LWU = 4'd6;
    localparam logic [3:0] OP_LD  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RESP  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd7);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= 4'd8) && (op <= 4'd11);
    endfunction

    // Access size: 0 byte, 1 half, 2 word, 3 double.
    function automatic logic [1:0] op_size(input logic [3:0] op);
        logic [1:0] size;
        case (op)
            OP_LB, OP_LBU, OP_SB: size = 2'd0;
            OP_LH, OP_LHU, OP_SH: size = 2'd1;
            OP_LW, OP_LWU, OP_SW: size = 2'd2;
            default:              size = 2'd3;
        endcase
        return size;
    endfunction

    // Lanes shifted past byte 7 fall off; a double always writes the whole word.
    function automatic logic [STRB_W-1:0] lane_strb(input logic [1:0] size, input logic [2:0] off);
        logic [15:0] wide;
        case (size)
            2'd0:    wide = 16'h0001 << off;
            2'd1:    wide = 16'h0003 << off;
            2'd2:    wide = 16'h000F << off;
            default: wide = 16'h00FF;
        endcase
        return wide[STRB_W-1:0];
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = off[0];
            2'd2:    mis = |off[1:0];
            default: mis = |off;
        endcase
        return mis;
    endfunction
`endif

    function automatic logic [XLEN-1:0] load_fmt(input logic [3:0] op, input logic [2:0] off,
                                                 input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh = rdata >> {off, 3'b000};
        case (op)
            OP_LB:   res = {{(XLEN-8){sh[7]}}, sh[7:0]};
            OP_LBU:  res = {{(XLEN-8){1'b0}}, sh[7:0]};
            OP_LH:   res = {{(XLEN-16){sh[15]}}, sh[15:0]};
            OP_LHU:  res = {{(XLEN-16){1'b0}}, sh[15:0]};
            OP_LW:   res = {{(XLEN-32){sh[31]}}, sh[31:0]};
            OP_LWU:  res = {{(XLEN-32){1'b0}}, sh[31:0]};
            OP_LD:   res = sh;
            default: res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    state_e               state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [2:0]           off_q, off_d;
    logic [XLEN-1:0]      addr_q, addr_d;
    logic                 wen_q, wen_d;
    logic [XLEN-1:0]      wdata_q, wdata_d;
    logic [STRB_W-1:0]    wstrb_q, wstrb_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [4:0]           rd_q, rd_d;
    logic                 out_valid_q, out_valid_d;
    logic [XLEN-1:0]      out_pc_q, out_pc_d;
    logic [4:0]           out_rd_q, out_rd_d;
    logic [XLEN-1:0]      out_data_q, out_data_d;
    logic [`TRAP_LEN-1:0] out_trap_q, out_trap_d;

    logic       accept_s, trap_in_s, is_mem_s, misal_s, mem_go_s;
    logic [1:0] in_size_s;

    // Decode of the incoming entry.
    always_comb begin
        in_size_s = op_size(mem_op_i);
        accept_s  = in_valid_i && !flush_i && (state_q == S_IDLE);
        trap_in_s = |trap_bus_i;
        is_mem_s  = is_load(mem_op_i) || is_store(mem_op_i);
`ifdef MEM_MISALIGN_TRAP_EN
        misal_s   = is_mem_s && misaligned(in_size_s, alu_data_i[2:0]);
`else
        misal_s   = 1'b0;
`endif
        mem_go_s  = accept_s && !trap_in_s && is_mem_s && !misal_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a flush in RESP must still absorb the outstanding response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mem_go_s) state_d = S_REQ;
                else          state_d = S_IDLE;
            end
            S_REQ: begin
                if (flush_i)          state_d = S_IDLE;
                else if (mem.req_ready) state_d = S_RESP;
                else                  state_d = S_REQ;
            end
            S_RESP: begin
                if (mem.resp_valid)   state_d = S_IDLE;
                else if (flush_i)     state_d = S_DRAIN;
                else                  state_d = S_RESP;
            end
            S_DRAIN: begin
                if (mem.resp_valid)   state_d = S_IDLE;
                else                  state_d = S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; a flush in REQ withdraws the request in the same cycle.
    always_comb begin
        in_ready_o     = (state_q == S_IDLE);
        mem.req_valid  = (state_q == S_REQ) && !flush_i;
        mem.req_addr   = addr_q;
        mem.req_wen    = wen_q;
        mem.req_wdata  = wdata_q;
        mem.req_wstrb  = wstrb_q;
        out_valid_o    = out_valid_q;
        out_pc_o       = out_pc_q;
        out_rd_idx_o   = out_rd_q;
        out_rd_data_o  = out_data_q;
        out_trap_bus_o = out_trap_q;
    end

    // Datapath next values: request latch on accept, result latch on completion.
    always_comb begin
        op_d        = op_q;
        off_d       = off_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        pc_d        = pc_q;
        rd_d        = rd_q;
        out_valid_d = 1'b0;
        out_pc_d    = out_pc_q;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
        out_trap_d  = out_trap_q;
        if (mem_go_s) begin
            op_d    = mem_op_i;
            off_d   = alu_data_i[2:0];
            addr_d  = {alu_data_i[XLEN-1:3], 3'b000};
            wen_d   = is_store(mem_op_i);
            wstrb_d = lane_strb(in_size_s, alu_data_i[2:0]);
            pc_d    = pc_i;
            rd_d    = rd_idx_i;
            if (is_store(mem_op_i)) wdata_d = rs2_data_i << {alu_data_i[2:0], 3'b000};
            else                    wdata_d = {XLEN{1'b0}};
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_i;
            out_rd_d    = rd_idx_i;
            if (misal_s) begin
                out_data_d = {XLEN{1'b0}};
                out_trap_d = {1'b1, (is_store(mem_op_i) ? 5'd6 : 5'd4), alu_data_i};
            end else begin
                out_data_d = alu_data_i;
                out_trap_d = trap_bus_i;
            end
        end else if ((state_q == S_RESP) && mem.resp_valid && !flush_i) begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_rd_d    = rd_q;
            out_trap_d  = {`TRAP_LEN{1'b0}};
            if (wen_q) out_data_d = {XLEN{1'b0}};
            else       out_data_d = load_fmt(op_q, off_q, mem.resp_rdata);
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= 4'd0;
            off_q       <= 3'd0;
            addr_q      <= {XLEN{1'b0}};
            wen_q       <= 1'b0;
            wdata_q     <= {XLEN{1'b0}};
            wstrb_q     <= {STRB_W{1'b0}};
            pc_q        <= {XLEN{1'b0}};
            rd_q        <= 5'd0;
            out_valid_q <= 1'b0;
            out_pc_q    <= {XLEN{1'b0}};
            out_rd_q    <= 5'd0;
            out_data_q  <= {XLEN{1'b0}};
            out_trap_q  <= {`TRAP_LEN{1'b0}};
        end else begin
            op_q        <= op_d;
            off_q       <= off_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            pc_q        <= pc_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
            out_trap_q  <= out_trap_d;
        end
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit; consumes the EX/MEM pipeline register outputs and drives the data-memory request/response interface as initiator.
- Formats load data: byte-lane select plus sign/zero extension.
- Presents a registered result to the MEM/WB register.
- Back-pressures EX/MEM via in_ready while a memory transaction is outstanding.

Parameters:
XLEN, 64, datapath and address width
STRB_W, XLEN/8, write-strobe width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_i  in  1  kill in-flight op (trap/redirect)
in_valid_i  in  1  EX/MEM entry valid
in_ready_o  out  1  LSU can accept entry this cycle
pc_i  in  XLEN  instruction pc
rd_idx_i  in  5  destination register
alu_data_i  in  XLEN  effective address / non-mem result
rs2_data_i  in  XLEN  store data
mem_op_i  in  4  memory op (`MEMOP_LEN)
trap_bus_i  in  `TRAP_LEN  incoming trap bus
req_valid_o  out  1  memory request valid
req_ready_i  in  1  memory accepts request
req_addr_o  out  XLEN  byte address
req_wen_o  out  1  1 = store
req_wdata_o  out  XLEN  lane-shifted store data
req_wstrb_o  out  STRB_W  byte strobes
resp_valid_i  in  1  response valid (one pulse per request)
resp_rdata_i  in  XLEN  aligned 64-bit read word
out_valid_o  out  1  result valid to MEM/WB
out_pc_o  out  XLEN  pc
out_rd_idx_o  out  5  rd
out_rd_data_o  out  XLEN  load data or passed-through alu_data
out_trap_bus_o  out  `TRAP_LEN  trap bus (misalign cause merged)

Behaviour:
- Reset and sync: clk and rst only; rst is synchronous, active-high.
- Reset values: state=IDLE; out_valid_o=0; req_valid_o=0; all data outputs 0; in_ready_o=1.
- mem_op encoding:
  - 0 NONE
  - Loads: 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD
  - Stores: 8 SB, 9 SH, 10 SW, 11 SD
  - 12-15 treated as NONE
- State machine (IDLE, REQ, RESP, DRAIN):
  - IDLE, in_valid&NONE: latch to output regs; out_valid_o=1 next cycle (latency 1); stay IDLE.
  - IDLE, in_valid&mem op: latch op/addr/data; go REQ; in_ready_o=0 until back in IDLE.
  - REQ: req_valid_o=1, fields stable until req_ready_i; on handshake go RESP.
  - RESP: on resp_valid_i, format data, out_valid_o=1 next cycle; go IDLE.
- Stores: completion is still the response pulse; out_rd_data_o=0 for stores.
- Lane handling, off=addr[2:0]:
  - req_addr_o = alu_data with low 3 bits cleared.
  - wstrb: SB=1<<off, SH=3<<off, SW=0xF<<off, SD=0xFF.
  - wdata: rs2_data << (8*off).
  - Load: (rdata >> 8*off), truncated to size, then sign- or zero-extended per op.
- out_valid_o is a single-cycle pulse per accepted entry; MEM/WB never stalls.
- flush_i:
  - IDLE/REQ: drop the entry, no request issued, go IDLE next cycle, no out_valid.
  - RESP: go DRAIN. DRAIN waits for resp_valid_i, discards it, goes IDLE. Outstanding responses are never orphaned.
  - flush_i has priority over in_valid_i in the same cycle.
- Same-cycle events:
  - req_ready_i is already high when REQ is entered: handshake completes that REQ cycle.
  - resp_valid_i asserts while in IDLE/REQ: protocol violation, ignored.
- Incoming trap: if trap_bus_i is non-zero, the op is treated as NONE and the bus is passed through. No memory side-effect.
- Reset mid-transaction: returns to IDLE immediately. Memory side must be reset in the same cycle.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined:
  - H at odd addr, W at addr[1:0]!=0, or D at addr[2:0]!=0 gives no request.
  - Load sets cause 4 in out_trap_bus_o; store sets cause 6. mtval = address.
  - out_valid_o=1 next cycle (latency 1).
- Undefined: the access is issued with only in-word bytes, i.e. strobe bits beyond lane 7 are dropped. No trap is raised.

Test Plan:
- Reset: rst high 2 cycles with in_valid_i=1 -> out_valid_o=0, req_valid_o=0, in_ready_o=1 throughout.
- Non-mem passthrough: mem_op=0, alu_data=0x1234, rd=5 -> next cycle out_valid_o=1, out_rd_data_o=0x1234, rd=5, no req_valid_o.
- Byte load with ready stall: LB at 0x80000003, req_ready_i low 3 cycles, resp_rdata=0x00000000_80FF0000 -> req_addr_o=0x80000000 held stable; out_rd_data_o=0xFFFFFFFF_FFFFFF80. LBU on the same word -> 0x80.
- Half-word store: SH at 0x80000006, rs2=0xABCD -> req_wstrb_o=0xC0, req_wdata_o=0xABCD0000_00000000, req_wen_o=1, out_valid_o one pulse after resp.
- Flush in RESP: LD accepted, flush_i pulsed in RESP, resp 2 cycles later -> no out_valid_o, in_ready_o=1 one cycle after the resp.
- Misaligned word load: LW at 0x80000002 with MEM_MISALIGN_TRAP_EN -> no req_valid_o, trap cause 4, mtval 0x80000002. Without the macro -> request issued with strobe 0x3C.
